// File: rtl/reg_pipeline.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready handshakes on both sides.
// Define REG_PIPELINE_OCC_EN to add the registered occupancy count output.
module reg_pipeline #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef REG_PIPELINE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] w_accept;
    logic [DEPTH-1:0] w_load_valid;
    logic [WIDTH-1:0] w_load_data [DEPTH];

    // Stage k accepts when it, or any stage between it and the output, has a hole, or the sink is ready.
    always_comb begin
        logic v_chain;
        v_chain  = out_ready;
        w_accept = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            v_chain     = v_chain || !r_valid[k];
            w_accept[k] = v_chain;
        end
    end

    assign in_ready  = w_accept[0] && !flush && !clr;
    assign out_data  = r_data[DEPTH-1];
    assign out_valid = r_valid[DEPTH-1];

    // Candidate word for each stage: upstream input for stage 0, the preceding stage otherwise.
    always_comb begin
        w_load_valid = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_load_data[k] = '0;
        end
        w_load_valid[0] = in_valid && in_ready;
        w_load_data[0]  = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            w_load_valid[k] = r_valid[k-1];
            w_load_data[k]  = r_data[k-1];
        end
    end

    // Stage registers; data is only written when a valid word lands, so stalled or empty stages never toggle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (flush) begin
                    r_valid[k] <= 1'b0;
                end else if (w_accept[k]) begin
                    r_valid[k] <= w_load_valid[k];
                end else begin
                    r_valid[k] <= r_valid[k];
                end
                if (!flush && w_accept[k] && w_load_valid[k]) begin
                    r_data[k] <= w_load_data[k];
                end
            end
        end
    end

`ifdef REG_PIPELINE_OCC_EN
    localparam int OW = $clog2(DEPTH + 1);

    logic [OW-1:0] r_occ;
    logic          w_xfer_in;
    logic          w_xfer_out;

    assign w_xfer_in  = in_valid && in_ready;
    assign w_xfer_out = r_valid[DEPTH-1] && out_ready;
    assign occupancy  = r_occ;

    // Count tracks the number of set valid bits; internal stage moves never change it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OW'(w_xfer_in) - OW'(w_xfer_out);
        end
    end
`endif

endmodule

// File: tb/tb_reg_pipeline.sv
// Self-checking bench for reg_pipeline: directed scenarios plus a randomized queue-based reference model.
module tb_reg_pipeline;

    typedef struct packed {
        logic [31:0] d;
        int          t;
    } item_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        flush;
    logic [3:0]  b_iv;
    logic [3:0]  b_ordy;
    logic [3:0]  b_irdy;
    logic [3:0]  b_ov;
    logic [31:0] b_id [4];
    logic [31:0] b_od [4];
    logic [15:0] w_od0;
    logic [15:0] w_od1;
    logic [0:0]  w_od2;
    logic [31:0] w_od3;
    int          checks = 0;
    int          errors = 0;
    int          edges  = 0;
    item_t       q [4][$];

    always #5 clk = ~clk;

    assign b_od[0] = {16'h0000, w_od0};
    assign b_od[1] = {16'h0000, w_od1};
    assign b_od[2] = {31'h00000000, w_od2};
    assign b_od[3] = w_od3;

`ifdef REG_PIPELINE_OCC_EN
    logic [1:0] w_occ0;
    logic [1:0] w_occ1;
    logic [0:0] w_occ2;
    logic [2:0] w_occ3;
    int         b_occ [4];
    assign b_occ[0] = int'(w_occ0);
    assign b_occ[1] = int'(w_occ1);
    assign b_occ[2] = int'(w_occ2);
    assign b_occ[3] = int'(w_occ3);
`endif

    reg_pipeline #(.WIDTH(16), .DEPTH(2)) u0 (
        .clk(clk), .clr(clr), .flush(flush), .in_data(b_id[0][15:0]), .in_valid(b_iv[0]),
        .in_ready(b_irdy[0]), .out_data(w_od0), .out_valid(b_ov[0]), .out_ready(b_ordy[0])
`ifdef REG_PIPELINE_OCC_EN
        , .occupancy(w_occ0)
`endif
    );
    reg_pipeline #(.WIDTH(16), .DEPTH(3)) u1 (
        .clk(clk), .clr(clr), .flush(flush), .in_data(b_id[1][15:0]), .in_valid(b_iv[1]),
        .in_ready(b_irdy[1]), .out_data(w_od1), .out_valid(b_ov[1]), .out_ready(b_ordy[1])
`ifdef REG_PIPELINE_OCC_EN
        , .occupancy(w_occ1)
`endif
    );
    reg_pipeline #(.WIDTH(1), .DEPTH(1)) u2 (
        .clk(clk), .clr(clr), .flush(flush), .in_data(b_id[2][0:0]), .in_valid(b_iv[2]),
        .in_ready(b_irdy[2]), .out_data(w_od2), .out_valid(b_ov[2]), .out_ready(b_ordy[2])
`ifdef REG_PIPELINE_OCC_EN
        , .occupancy(w_occ2)
`endif
    );
    reg_pipeline #(.WIDTH(32), .DEPTH(4)) u3 (
        .clk(clk), .clr(clr), .flush(flush), .in_data(b_id[3]), .in_valid(b_iv[3]),
        .in_ready(b_irdy[3]), .out_data(w_od3), .out_valid(b_ov[3]), .out_ready(b_ordy[3])
`ifdef REG_PIPELINE_OCC_EN
        , .occupancy(w_occ3)
`endif
    );

    function automatic int dep_of(input int i);
        case (i)
            0: return 2;
            1: return 3;
            2: return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input int i);
        case (i)
            0, 1: return 32'h0000FFFF;
            2: return 32'h00000001;
            default: return 32'hFFFFFFFF;
        endcase
    endfunction

    task automatic drive(input int i, input logic v, input logic [31:0] d, input logic r);
        b_iv[i]   = v;
        b_id[i]   = d;
        b_ordy[i] = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr    = 1'b1;
        flush  = 1'b0;
        b_iv   = '0;
        b_ordy = '0;
        for (int i = 0; i < 4; i++) b_id[i] = '0;
        @(negedge clk);
        clr   = 1'b0;
        edges = 0;
    endtask

    task automatic test_reset();
        #3;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b_ov[i] !== 1'b0 || b_od[i] !== 32'h0 || b_irdy[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d got ov=%b od=%h irdy=%b want 0/0/0", i, b_ov[i], b_od[i], b_irdy[i]);
            end
`ifdef REG_PIPELINE_OCC_EN
            checks++;
            if (b_occ[i] !== 0) begin
                errors++;
                $display("FAIL reset_occ inst=%0d got %0d want 0", i, b_occ[i]);
            end
`endif
        end
        @(negedge clk);
        clr = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (b_irdy[i] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release_ready inst=%0d got %b want 1", i, b_irdy[i]);
            end
        end
    endtask

    task automatic test_streaming();
        logic exp_v;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(0, c < 5, 32'(c + 1), 1'b1);
            #1;
            if (c < 5) begin
                checks++;
                if (b_irdy[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_in_ready c=%0d got %b want 1", c, b_irdy[0]);
                end
            end
            exp_v = (c >= 2 && c <= 6);
            checks++;
            if (b_ov[0] !== exp_v) begin
                errors++;
                $display("FAIL stream_out_valid c=%0d got %b want %b", c, b_ov[0], exp_v);
            end
            if (exp_v) begin
                checks++;
                if (b_od[0] !== 32'(c - 1)) begin
                    errors++;
                    $display("FAIL stream_out_data c=%0d got %h want %h", c, b_od[0], 32'(c - 1));
                end
            end
            @(negedge clk);
        end
        drive(0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [7:0]  iv_t   = 8'b0001_1111;
        logic [7:0]  or_t   = 8'b1111_0000;
        logic [7:0]  rdy_t  = 8'b1111_0011;
        logic [7:0]  ov_t   = 8'b0111_1100;
        logic [15:0] d_t  [8];
        logic [15:0] od_t [8];
`ifdef REG_PIPELINE_OCC_EN
        int occ_t [8];
        occ_t = '{0, 1, 2, 2, 2, 2, 1, 0};
`endif
        d_t  = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hCCCC, 16'hCCCC, 16'h0000, 16'h0000, 16'h0000};
        od_t = '{16'h0000, 16'h0000, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'h0000};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(0, iv_t[c], {16'h0000, d_t[c]}, or_t[c]);
            #1;
            checks++;
            if (b_irdy[0] !== rdy_t[c]) begin
                errors++;
                $display("FAIL bp_in_ready c=%0d got %b want %b", c, b_irdy[0], rdy_t[c]);
            end
            checks++;
            if (b_ov[0] !== ov_t[c]) begin
                errors++;
                $display("FAIL bp_out_valid c=%0d got %b want %b", c, b_ov[0], ov_t[c]);
            end
            if (ov_t[c]) begin
                checks++;
                if (b_od[0] !== {16'h0000, od_t[c]}) begin
                    errors++;
                    $display("FAIL bp_out_data c=%0d got %h want %h", c, b_od[0], od_t[c]);
                end
            end
`ifdef REG_PIPELINE_OCC_EN
            checks++;
            if (b_occ[0] !== occ_t[c]) begin
                errors++;
                $display("FAIL bp_occ c=%0d got %0d want %0d", c, b_occ[0], occ_t[c]);
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_full_simultaneous();
        logic [8:0]  iv_t  = 9'b0_0001_1111;
        logic [8:0]  or_t  = 9'b1_1111_0000;
        logic [8:0]  rdy_t = 9'b1_1111_0111;
        logic [8:0]  ov_t  = 9'b0_1111_1000;
        logic [15:0] d_t  [9];
        logic [15:0] od_t [9];
`ifdef REG_PIPELINE_OCC_EN
        int occ_t [9];
        occ_t = '{0, 1, 2, 3, 3, 3, 2, 1, 0};
`endif
        d_t  = '{16'h0011, 16'h0022, 16'h0033, 16'h1234, 16'h1234, 16'h0, 16'h0, 16'h0, 16'h0};
        od_t = '{16'h0, 16'h0, 16'h0, 16'h0011, 16'h0011, 16'h0022, 16'h0033, 16'h1234, 16'h0};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(1, iv_t[c], {16'h0000, d_t[c]}, or_t[c]);
            #1;
            checks++;
            if (b_irdy[1] !== rdy_t[c]) begin
                errors++;
                $display("FAIL full_in_ready c=%0d got %b want %b", c, b_irdy[1], rdy_t[c]);
            end
            checks++;
            if (b_ov[1] !== ov_t[c]) begin
                errors++;
                $display("FAIL full_out_valid c=%0d got %b want %b", c, b_ov[1], ov_t[c]);
            end
            if (ov_t[c]) begin
                checks++;
                if (b_od[1] !== {16'h0000, od_t[c]}) begin
                    errors++;
                    $display("FAIL full_out_data c=%0d got %h want %h", c, b_od[1], od_t[c]);
                end
            end
`ifdef REG_PIPELINE_OCC_EN
            checks++;
            if (b_occ[1] !== occ_t[c]) begin
                errors++;
                $display("FAIL full_occ c=%0d got %0d want %0d", c, b_occ[1], occ_t[c]);
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_flush();
        logic [6:0]  iv_t  = 7'b000_0111;
        logic [6:0]  or_t  = 7'b111_1000;
        logic [6:0]  fl_t  = 7'b000_0100;
        logic [6:0]  rdy_t = 7'b111_1011;
        logic [6:0]  ov_t  = 7'b000_0100;
        logic [15:0] d_t [7];
        d_t = '{16'h0101, 16'h0202, 16'hDEAD, 16'h0, 16'h0, 16'h0, 16'h0};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            drive(0, iv_t[c], {16'h0000, d_t[c]}, or_t[c]);
            flush = fl_t[c];
            #1;
            checks++;
            if (b_irdy[0] !== rdy_t[c]) begin
                errors++;
                $display("FAIL flush_in_ready c=%0d got %b want %b", c, b_irdy[0], rdy_t[c]);
            end
            checks++;
            if (b_ov[0] !== ov_t[c]) begin
                errors++;
                $display("FAIL flush_out_valid c=%0d got %b want %b od=%h", c, b_ov[0], ov_t[c], b_od[0]);
            end
            if (ov_t[c]) begin
                checks++;
                if (b_od[0] !== 32'h0101) begin
                    errors++;
                    $display("FAIL flush_out_data c=%0d got %h want 0101", c, b_od[0]);
                end
            end
`ifdef REG_PIPELINE_OCC_EN
            if (c == 3) begin
                checks++;
                if (b_occ[0] !== 0) begin
                    errors++;
                    $display("FAIL flush_occ got %0d want 0", b_occ[0]);
                end
            end
`endif
            @(negedge clk);
        end
        flush = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(0, 1'b1, 32'h1111, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 32'h2222, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (b_ov[0] !== 1'b1 || b_od[0] !== 32'h1111 || b_irdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL arst_full got ov=%b od=%h irdy=%b want 1/1111/0", b_ov[0], b_od[0], b_irdy[0]);
        end
        #2;
        clr = 1'b1;
        #1;
        checks++;
        if (b_ov[0] !== 1'b0 || b_od[0] !== 32'h0 || b_irdy[0] !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate got ov=%b od=%h irdy=%b want 0/0/0", b_ov[0], b_od[0], b_irdy[0]);
        end
        @(negedge clk);
        clr = 1'b0;
        drive(0, 1'b1, 32'h5A5A, 1'b1);
        #1;
        checks++;
        if (b_irdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL arst_release_ready got %b want 1", b_irdy[0]);
        end
        @(negedge clk);
        drive(0, 1'b0, 32'h0, 1'b1);
        #1;
        checks++;
        if (b_ov[0] !== 1'b0) begin
            errors++;
            $display("FAIL arst_latency_early got ov=%b want 0", b_ov[0]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (b_ov[0] !== 1'b1 || b_od[0] !== 32'h5A5A) begin
            errors++;
            $display("FAIL arst_first_word got ov=%b od=%h want 1/5a5a", b_ov[0], b_od[0]);
        end
        @(negedge clk);
    endtask

    // Reference: a FIFO of accepted words; the oldest becomes visible DEPTH-1 edges after acceptance.
    task automatic test_random();
        item_t      it;
        logic [3:0] e_rdy;
        logic [3:0] e_ov;
        do_reset();
        for (int i = 0; i < 4; i++) q[i].delete();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                b_iv[i]   = ($urandom_range(0, 9) < 7);
                b_ordy[i] = ($urandom_range(0, 9) < 5);
                b_id[i]   = $urandom() & mask_of(i);
            end
            #1;
            for (int i = 0; i < 4; i++) begin
                e_rdy[i] = (q[i].size() < dep_of(i)) || b_ordy[i];
                e_ov[i]  = (q[i].size() > 0) && ((edges - 1 - q[i][0].t) >= dep_of(i) - 1);
                checks++;
                if (b_irdy[i] !== e_rdy[i]) begin
                    errors++;
                    $display("FAIL rand_in_ready inst=%0d c=%0d got %b want %b", i, c, b_irdy[i], e_rdy[i]);
                end
                checks++;
                if (b_ov[i] !== e_ov[i]) begin
                    errors++;
                    $display("FAIL rand_out_valid inst=%0d c=%0d got %b want %b", i, c, b_ov[i], e_ov[i]);
                end
                if (e_ov[i]) begin
                    checks++;
                    if (b_od[i] !== q[i][0].d) begin
                        errors++;
                        $display("FAIL rand_out_data inst=%0d c=%0d got %h want %h", i, c, b_od[i], q[i][0].d);
                    end
                end
`ifdef REG_PIPELINE_OCC_EN
                checks++;
                if (b_occ[i] !== q[i].size()) begin
                    errors++;
                    $display("FAIL rand_occ inst=%0d c=%0d got %0d want %0d", i, c, b_occ[i], q[i].size());
                end
`endif
            end
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (e_ov[i] && b_ordy[i]) void'(q[i].pop_front());
                if (b_iv[i] && e_rdy[i]) begin
                    it.d = b_id[i];
                    it.t = edges;
                    q[i].push_back(it);
                end
            end
            edges++;
            @(negedge clk);
        end
        b_iv = '0;
    endtask

    initial begin
        clr    = 1'b1;
        flush  = 1'b0;
        b_iv   = '0;
        b_ordy = '1;
        for (int i = 0; i < 4; i++) b_id[i] = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_simultaneous();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
